// File: rtl/ram_master.sv
// rtl/ram_master.sv - burst initiator controller in front of a single-port ram
//
// Purpose: accepts burst read/write commands on a valid/ready request
// channel. It drives the ram en/we/addr/in pins and returns read beats on a
// valid/ready response channel.
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-low reset
//   req_valid/req_ready       command handshake
//   req_we/req_addr/req_len   command fields (len = beats - 1)
//   wd_valid/wd_ready/wd_data write-data stream
//   rsp_valid/rsp_ready       read-data response handshake
//   rsp_data/rsp_last         read-data response payload and last-beat flag
//   busy                      controller is not idle
//   ram_en/ram_we/ram_addr/ram_din/ram_dout  ram pins
module ram_master #(
    parameter int DW     = 10,
    parameter int AW     = 8,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [DW-1:0]    wd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_last,
    output logic             busy,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout
);

    localparam int LAT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RD_RSP
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic [AW-1:0]      addr_hold_q, addr_hold_d;
    logic [DW-1:0]      din_hold_q, din_hold_d;

    logic               req_ready_c, wd_ready_c, rsp_valid_c, rsp_last_c;
    logic               ram_en_c, ram_we_c;
    logic [AW-1:0]      ram_addr_c;
    logic [DW-1:0]      ram_din_c;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        rsp_data_d  = rsp_data_q;
        req_ready_c = 1'b0;
        wd_ready_c  = 1'b0;
        rsp_valid_c = 1'b0;
        rsp_last_c  = 1'b0;
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        // ram address/data pins hold their last driven value when unused
        ram_addr_c  = addr_hold_q;
        ram_din_c   = din_hold_q;

        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                if (req_valid) begin
                    cur_addr_d = req_addr;
                    len_d      = req_len;
                    cnt_d      = '0;
                    state_d    = req_we ? WR : RD_ISSUE;
                end
            end
            WR: begin
                wd_ready_c = 1'b1;
                ram_en_c   = wd_valid;
                ram_we_c   = wd_valid;
                ram_addr_c = cur_addr_q;
                ram_din_c  = wd_data;
                if (wd_valid) begin
                    cur_addr_d = cur_addr_q + AW'(1);
                    cnt_d      = cnt_q + LEN_W'(1);
                    if (cnt_q == len_q) begin
                        state_d = IDLE;
                    end
                end
            end
            RD_ISSUE: begin
                ram_en_c   = 1'b1;
                ram_addr_c = cur_addr_q;
                lat_d      = '0;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                // ram out is valid RD_LAT cycles after the issue edge
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    rsp_data_d = ram_dout;
                    state_d    = RD_RSP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RD_RSP: begin
                rsp_valid_c = 1'b1;
                rsp_last_c  = (cnt_q == len_q);
                if (rsp_ready) begin
                    cur_addr_d = cur_addr_q + AW'(1);
                    cnt_d      = cnt_q + LEN_W'(1);
                    state_d    = (cnt_q == len_q) ? IDLE : RD_ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        addr_hold_d = ram_addr_c;
        din_hold_d  = ram_din_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            rsp_data_q  <= '0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            rsp_data_q  <= rsp_data_d;
            addr_hold_q <= addr_hold_d;
            din_hold_q  <= din_hold_d;
        end
    end

    // Every output is forced low for as long as reset is asserted.
    assign req_ready = rst & req_ready_c;
    assign wd_ready  = rst & wd_ready_c;
    assign rsp_valid = rst & rsp_valid_c;
    assign rsp_last  = rst & rsp_last_c;
    assign busy      = rst & (state_q != IDLE);
    assign ram_en    = rst & ram_en_c;
    assign ram_we    = rst & ram_we_c;
    assign ram_addr  = rst ? ram_addr_c : '0;
    assign ram_din   = rst ? ram_din_c : '0;
    assign rsp_data  = rst ? rsp_data_q : '0;

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - directed self-checking bench for ram_master
module tb_ram_master;

    localparam int DW     = 10;
    localparam int AW     = 8;
    localparam int LEN_W  = 4;
    localparam int RD_LAT = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [LEN_W-1:0] req_len = '0;
    logic             wd_valid = 1'b0;
    logic             wd_ready;
    logic [DW-1:0]    wd_data = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [DW-1:0]    rsp_data;
    logic             rsp_last;
    logic             busy;
    logic             ram_en;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [DW-1:0]    ram_din;
    logic [DW-1:0]    ram_dout;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int wr_cnt = 0;
    int rdy_busy = 0;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] wbuf [16];
    logic [DW-1:0] rbuf [16];

    always #5 clk = ~clk;

    ram_master #(.DW(DW), .AW(AW), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // single-port ram, one cycle read latency
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_dout = '0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_en)           en_cnt <= en_cnt + 1;
        if (ram_en && ram_we) wr_cnt <= wr_cnt + 1;
        if (busy && req_ready) rdy_busy <= rdy_busy + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [LEN_W-1:0] len);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = len;
        while (!req_ready && n < 100) begin
            tick;
            n++;
        end
        check("req_ready", {31'd0, req_ready}, 1);
        tick;
        req_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int len, input int gap, input bit hold);
        int n;
        send_req(1'b1, addr, LEN_W'(len));
        if (hold) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
        end
        for (int b = 0; b <= len; b++) begin
            wd_valid = 1'b0;
            repeat (gap) tick;
            wd_valid = 1'b1;
            wd_data  = wbuf[b];
            n = 0;
            while (!wd_ready && n < 50) begin
                tick;
                n++;
            end
            check("wd_ready", {31'd0, wd_ready}, 1);
            tick;
        end
        wd_valid = 1'b0;
        check("wr_done_busy", {31'd0, busy}, 0);
        if (hold) begin
            check("wr_done_req_ready", {31'd0, req_ready}, 1);
            req_valid = 1'b0;
        end
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int len, input int stall);
        int n;
        send_req(1'b0, addr, LEN_W'(len));
        for (int b = 0; b <= len; b++) begin
            n = 0;
            while (!rsp_valid && n < 50) begin
                tick;
                n++;
            end
            check(b == 0 ? "rd_latency" : "rd_period", n + 1, RD_LAT + 2);
            check("rd_data", {22'd0, rsp_data}, {22'd0, rbuf[b]});
            check("rd_last", {31'd0, rsp_last}, (b == len) ? 1 : 0);
            for (int s = 0; s < stall; s++) begin
                rsp_ready = 1'b0;
                tick;
                check("stall_valid", {31'd0, rsp_valid}, 1);
                check("stall_data", {22'd0, rsp_data}, {22'd0, rbuf[b]});
            end
            rsp_ready = 1'b1;
            tick;
            rsp_ready = 1'b0;
        end
        check("rd_done_busy", {31'd0, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int e0, w0, r0, n;

        // 1. reset with a pending request
        rst = 1'b0;
        req_valid = 1'b1;
        tick;
        tick;
        check("rst_req_ready", {31'd0, req_ready}, 0);
        check("rst_ram_en", {31'd0, ram_en}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        req_valid = 1'b0;
        rst = 1'b1;
        tick;
        check("idle_req_ready", {31'd0, req_ready}, 1);

        // 2. single-beat writes and reads
        wbuf[0] = 10'd5;   write_burst(8'd1,   0, 0, 1'b0);
        wbuf[0] = 10'd60;  write_burst(8'd3,   0, 0, 1'b0);
        wbuf[0] = 10'd100; write_burst(8'd15,  0, 0, 1'b0);
        wbuf[0] = 10'd420; write_burst(8'd200, 0, 0, 1'b0);
        rbuf[0] = 10'd5;   read_burst(8'd1,   0, 0);
        rbuf[0] = 10'd60;  read_burst(8'd3,   0, 0);
        rbuf[0] = 10'd100; read_burst(8'd15,  0, 0);
        rbuf[0] = 10'd420; read_burst(8'd200, 0, 0);
        rbuf[0] = 10'd0;   read_burst(8'd68,  0, 0);

        // 3. burst wrapping past the top address
        wbuf[0] = 10'd11; wbuf[1] = 10'd22; wbuf[2] = 10'd33; wbuf[3] = 10'd44;
        write_burst(8'd254, 3, 0, 1'b0);
        check("mem_254", {22'd0, mem[254]}, 11);
        check("mem_255", {22'd0, mem[255]}, 22);
        check("mem_0",   {22'd0, mem[0]},   33);
        check("mem_1",   {22'd0, mem[1]},   44);
        rbuf[0] = 10'd11; rbuf[1] = 10'd22; rbuf[2] = 10'd33; rbuf[3] = 10'd44;
        read_burst(8'd254, 3, 0);

        // 4. response backpressure: addrs 1,2,3 hold 44,0,60
        e0 = en_cnt;
        rbuf[0] = 10'd44; rbuf[1] = 10'd0; rbuf[2] = 10'd60;
        read_burst(8'd1, 2, 5);
        check("stall_en_pulses", en_cnt - e0, 3);

        // 5. write-data gaps with a competing request held high
        w0 = wr_cnt;
        r0 = rdy_busy;
        wbuf[0] = 10'd501; wbuf[1] = 10'd502; wbuf[2] = 10'd503; wbuf[3] = 10'd504;
        write_burst(8'd40, 3, 3, 1'b1);
        check("gap_wr_count", wr_cnt - w0, 4);
        check("gap_rdy_busy", rdy_busy - r0, 0);
        check("mem_43", {22'd0, mem[43]}, 504);

        // 6. reset in the middle of a long read
        send_req(1'b0, 8'd254, 4'd7);
        n = 0;
        while (!rsp_valid && n < 50) begin tick; n++; end
        check("abort_beat0", {22'd0, rsp_data}, 11);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin tick; n++; end
        check("abort_beat1", {22'd0, rsp_data}, 22);
        e0 = en_cnt;
        rst = 1'b0;
        tick;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 0);
        tick;
        rst = 1'b1;
        tick;
        tick;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_en", en_cnt - e0, 0);
        wbuf[0] = 10'd7; wbuf[1] = 10'd8;
        write_burst(8'd10, 1, 0, 1'b0);
        rbuf[0] = 10'd7; rbuf[1] = 10'd8;
        read_burst(8'd10, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
